// File: rtl/muldiv_seq_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_seq_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] srcA;
    logic [DATA_WIDTH-1:0] srcB;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic                  we_hi;
    logic                  we_lo;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;
    logic                  div_by_zero;

    modport master (
        output start, op, srcA, srcB, flush,
        input  busy, done, we_hi, we_lo, hi_out, lo_out, div_by_zero
    );

    modport slave (
        input  start, op, srcA, srcB, flush,
        output busy, done, we_hi, we_lo, hi_out, lo_out, div_by_zero
    );
endinterface

// File: rtl/muldiv_seq_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU sequencer producing a one-cycle HI/LO write.
module muldiv_seq_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_seq_unit_if.slave  bus
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned W2 = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state_q, state_d;
    logic           div_q, div_d;
    logic           neg_q, neg_d;
    logic           neg_rem_q, neg_rem_d;
    logic [W-1:0]   a_q, a_d;       // multiplicand or divisor magnitude
    logic [W-1:0]   m_q, m_d;       // multiplier, or dividend shifting into quotient
    logic [W-1:0]   acc_q, acc_d;   // product high half or partial remainder
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic           dbz_q, dbz_d;
    logic           busy_q, done_q;

    logic           accept, sa, sb;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     sum, rem_sh, diff;
    logic [W2-1:0]  prod, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        a_d       = a_q;
        m_d       = m_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = 1'b0;

        accept   = bus.start && !bus.flush && (state_q == IDLE || state_q == DONE);
        sa       = !bus.op[0] && bus.srcA[W-1];
        sb       = !bus.op[0] && bus.srcB[W-1];
        abs_a    = sa ? (~bus.srcA + W'(1)) : bus.srcA;
        abs_b    = sb ? (~bus.srcB + W'(1)) : bus.srcB;

        sum      = {1'b0, acc_q} + {1'b0, a_q & {W{m_q[0]}}};
        rem_sh   = {acc_q, m_q[W-1]};
        diff     = rem_sh - {1'b0, a_q};
        prod     = {acc_q, m_q};
        prod_fix = neg_q ? (~prod + W2'(1)) : prod;
        quo_fix  = neg_q ? (~m_q + W'(1)) : m_q;
        rem_fix  = neg_rem_q ? (~acc_q + W'(1)) : acc_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    div_d     = bus.op[1];
                    neg_d     = sa ^ sb;
                    neg_rem_d = sa;
                    acc_d     = '0;
                    cnt_d     = '0;
                    if (bus.op[1]) begin
                        a_d = abs_b;
                        m_d = abs_a;
                    end else begin
                        a_d = abs_a;
                        m_d = abs_b;
                    end
                    if (bus.op[1] && bus.srcB == '0) begin
                        state_d = DONE;
                        hi_d    = bus.srcA;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (div_q) begin
                    if (!diff[W]) begin
                        acc_d = diff[W-1:0];
                        m_d   = {m_q[W-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[W-1:0];
                        m_d   = {m_q[W-2:0], 1'b0};
                    end
                end else begin
                    acc_d = sum[W:1];
                    m_d   = {sum[0], m_q[W-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) state_d = FIX;
            end
            FIX: begin
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[W2-1:W];
                    lo_d = prod_fix[W-1:0];
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Cancel wins over everything, including a same-cycle start
        if (bus.flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            a_q       <= a_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
            busy_q    <= (state_d == CALC) || (state_d == FIX);
            done_q    <= (state_d == DONE);
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.we_hi       = done_q;
    assign bus.we_lo       = done_q;
    assign bus.hi_out      = hi_q;
    assign bus.lo_out      = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed-vector bench for muldiv_seq_unit with hand-computed HI/LO results.
module tb_muldiv_seq_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   dcyc, bcnt;

    always #5 clk = ~clk;

    muldiv_seq_unit_if #(.DATA_WIDTH(32)) bus ();

    muldiv_seq_unit #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Call right after a falling edge; returns just after the accepting rising edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op    = op;
        bus.srcA  = a;
        bus.srcB  = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.flush = 1'b0;
    endtask

    // Cycle n is sampled at the n-th falling edge after the start edge; -1 means no done.
    task automatic watch(output int done_cyc, output int busy_cnt, input int limit);
        done_cyc = -1;
        busy_cnt = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.srcA  = '0;
        bus.srcB  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_we", 64'({bus.we_hi, bus.we_lo}), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        chk("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // MULTU all-ones squared
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        watch(dcyc, bcnt, 60);
        chk("multu_done_cyc", 64'(dcyc), 64'd34);
        chk("multu_busy_cnt", 64'(bcnt), 64'd33);
        chk("multu_hi", 64'(bus.hi_out), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(bus.lo_out), 64'h0000_0001);
        chk("multu_we", 64'({bus.we_hi, bus.we_lo}), 64'd3);
        chk("multu_dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        chk("multu_done_pulse", 64'(bus.done), 64'd0);

        // MULT -3 * 5, then DIV -7 / 2 started while DONE
        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        watch(dcyc, bcnt, 60);
        chk("mult_done_cyc", 64'(dcyc), 64'd34);
        chk("mult_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(bus.lo_out), 64'hFFFF_FFF1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        watch(dcyc, bcnt, 60);
        chk("b2b_div_done_cyc", 64'(dcyc), 64'd34);
        chk("b2b_div_lo", 64'(bus.lo_out), 64'hFFFF_FFFD);
        chk("b2b_div_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);

        // DIVU by zero
        @(negedge clk);
        issue(2'b11, 32'h64, 32'h0);
        watch(dcyc, bcnt, 5);
        chk("dz_done_cyc", 64'(dcyc), 64'd1);
        chk("dz_busy_cnt", 64'(bcnt), 64'd0);
        chk("dz_flag", 64'(bus.div_by_zero), 64'd1);
        chk("dz_hi", 64'(bus.hi_out), 64'h64);
        chk("dz_lo", 64'(bus.lo_out), 64'hFFFF_FFFF);
        @(negedge clk);
        chk("dz_flag_pulse", 64'(bus.div_by_zero), 64'd0);

        // Most-negative dividend over -1
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        watch(dcyc, bcnt, 60);
        chk("ovf_done_cyc", 64'(dcyc), 64'd34);
        chk("ovf_lo", 64'(bus.lo_out), 64'h8000_0000);
        chk("ovf_hi", 64'(bus.hi_out), 64'h0);
        chk("ovf_dbz", 64'(bus.div_by_zero), 64'd0);

        // Flush in cycle 10 of a MULTU
        @(negedge clk);
        issue(2'b01, 32'd7, 32'd9);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        watch(dcyc, bcnt, 40);
        chk("flush_no_done", 64'(dcyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("flush_hilo", {bus.hi_out, bus.lo_out}, 64'h0000_0000_8000_0000);

        // Flush together with start
        bus.flush = 1'b1;
        issue(2'b01, 32'd3, 32'd3);
        @(negedge clk);
        chk("flush_start_busy", 64'(bus.busy), 64'd0);
        watch(dcyc, bcnt, 40);
        chk("flush_start_no_done", 64'(dcyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("flush_start_hilo", {bus.hi_out, bus.lo_out}, 64'h0000_0000_8000_0000);

        // Reset mid-DIVU, then a fresh DIVU 100 / 7
        issue(2'b11, 32'd1000, 32'd3);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(2'b11, 32'd100, 32'd7);
        watch(dcyc, bcnt, 60);
        chk("divu_done_cyc", 64'(dcyc), 64'd34);
        chk("divu_lo", 64'(bus.lo_out), 64'd14);
        chk("divu_hi", 64'(bus.hi_out), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
